// File: rtl/lane_sum_pkg.sv
// Shared types and the per-lane reduction step used by lane_sum_acc.
// The step works on a fixed-width word; the accumulator lives in its low out_w bits.
package lane_sum_pkg;

  localparam int unsigned STEP_W = 64;

  typedef enum logic [1:0] {
    MODE_USUM = 2'b00,
    MODE_SSUM = 2'b01,
    MODE_POPC = 2'b10,
    MODE_MAX  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef logic [STEP_W-1:0] step_word_t;

  typedef struct packed {
    logic       ovf;
    step_word_t acc;
  } step_t;

  // Fold one lane into the accumulator; operands are pre-extended to out_w bits.
  function automatic step_t fold_step(
    input mode_t       mode,
    input step_word_t  acc,
    input step_word_t  lane_zx,
    input step_word_t  lane_sx,
    input step_word_t  lane_pc,
    input int unsigned out_w
  );
    logic [STEP_W:0] sum;
    step_word_t      mask;
    step_word_t      res;
    logic            sa;
    logic            sb;
    logic            sr;
    step_t           r;
    mask  = (out_w >= STEP_W) ? '1 : ((STEP_W'(1) << out_w) - STEP_W'(1));
    sum   = '0;
    res   = '0;
    sa    = 1'b0;
    sb    = 1'b0;
    sr    = 1'b0;
    r.acc = acc;
    r.ovf = 1'b0;
    case (mode)
      MODE_USUM: begin
        sum   = {1'b0, acc} + {1'b0, lane_zx};
        r.acc = sum[STEP_W-1:0] & mask;
        r.ovf = (sum >> out_w) != '0;
      end
      MODE_SSUM: begin
        sum   = {1'b0, acc} + {1'b0, lane_sx};
        res   = sum[STEP_W-1:0] & mask;
        sa    = ((acc >> (out_w - 1)) & STEP_W'(1)) != '0;
        sb    = ((lane_sx >> (out_w - 1)) & STEP_W'(1)) != '0;
        sr    = ((res >> (out_w - 1)) & STEP_W'(1)) != '0;
        r.acc = res;
        r.ovf = (sa == sb) && (sr != sa);
      end
      MODE_POPC: r.acc = (acc + lane_pc) & mask;
      MODE_MAX:  r.acc = (lane_zx > acc) ? lane_zx : acc;
      default:   r.acc = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lane_sum_acc_fold.sv
// Combinational fold of one group of lanes into the running accumulator,
// lowest-numbered lane first; the overflow bit is the OR over the group.
module lane_fold
  import lane_sum_pkg::*;
#(
  parameter int unsigned LANE_W        = 8,
  parameter int unsigned LANES_PER_CYC = 1,
  parameter int unsigned OUT_W         = 32
) (
  input  logic [LANES_PER_CYC*LANE_W-1:0] lanes_i,
  input  logic [OUT_W-1:0]                acc_i,
  input  mode_t                           mode_i,
  output logic [OUT_W-1:0]                acc_c,
  output logic                            ovf_c
);

  step_word_t        acc;
  step_word_t        lane_zx;
  step_word_t        lane_sx;
  step_word_t        lane_pc;
  step_t             st;
  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  lane_ext;
  logic              ovf;

  always_comb begin
    acc      = STEP_W'(acc_i);
    ovf      = 1'b0;
    lane     = '0;
    lane_ext = '0;
    lane_zx  = '0;
    lane_sx  = '0;
    lane_pc  = '0;
    st       = '0;
    for (int i = 0; i < int'(LANES_PER_CYC); i++) begin
      lane     = lanes_i[i*LANE_W +: LANE_W];
      lane_ext = OUT_W'($signed(lane));
      lane_zx  = STEP_W'(lane);
      lane_sx  = STEP_W'(lane_ext);
      lane_pc  = STEP_W'($countones(lane));
      st       = fold_step(mode_i, acc, lane_zx, lane_sx, lane_pc, OUT_W);
      acc      = st.acc;
      ovf      = ovf | st.ovf;
    end
    acc_c = OUT_W'(acc);
    ovf_c = ovf;
  end

endmodule

// File: rtl/lane_sum_acc.sv
// Multi-cycle lane reducer: captures a word on start, folds LANES_PER_CYC lanes
// per BUSY cycle, and presents the result with finish while start is held.
module lane_sum_acc
  import lane_sum_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned LANE_W        = 8,
  parameter int unsigned LANES_PER_CYC = 1,
  parameter int unsigned OUT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in,
  output logic              finish,
  output logic              busy,
  output logic [OUT_W-1:0]  result,
  output logic              ovf
);

  localparam int unsigned NUM_LANES = DATA_W / LANE_W;
  localparam int unsigned NUM_CYC   = NUM_LANES / LANES_PER_CYC;
  localparam int unsigned GRP_W     = LANES_PER_CYC * LANE_W;
  localparam int unsigned IDX_W     = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;

  if (DATA_W % LANE_W != 0) begin : g_bad_lane_w
    $error("lane_sum_acc: DATA_W must be a multiple of LANE_W");
  end
  if (NUM_LANES % LANES_PER_CYC != 0) begin : g_bad_lpc
    $error("lane_sum_acc: NUM_LANES must be a multiple of LANES_PER_CYC");
  end
  if (OUT_W < LANE_W || OUT_W < $clog2(DATA_W + 1) || OUT_W > STEP_W) begin : g_bad_out_w
    $error("lane_sum_acc: OUT_W out of range");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  mode_t             mode_q, mode_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              run_ovf_q, run_ovf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [OUT_W-1:0]  fold_acc;
  logic              fold_ovf;
  logic              last_grp;

  // The operand shifts down each BUSY cycle, so the next group is always at the bottom.
  lane_fold #(
    .LANE_W        (LANE_W),
    .LANES_PER_CYC (LANES_PER_CYC),
    .OUT_W         (OUT_W)
  ) u_fold (
    .lanes_i (opnd_q[GRP_W-1:0]),
    .acc_i   (acc_q),
    .mode_i  (mode_q),
    .acc_c   (fold_acc),
    .ovf_c   (fold_ovf)
  );

  assign last_grp = (idx_q == IDX_W'(NUM_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Dropping start anywhere returns to IDLE; abort wins over the last group.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY: begin
        if (!start)        state_d = IDLE;
        else if (last_grp) state_d = DONE;
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs lag the state by one edge; result and ovf load only as finish rises.
  always_comb begin
    opnd_d    = opnd_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    run_ovf_d = run_ovf_q;
    idx_d     = idx_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    busy_d    = (state_q == BUSY) && start;
    finish_d  = (state_q == DONE) && start;
    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d    = in;
          mode_d    = mode_t'(mode);
          acc_d     = '0;
          run_ovf_d = 1'b0;
          idx_d     = '0;
        end
      end
      BUSY: begin
        if (start) begin
          opnd_d    = opnd_q >> GRP_W;
          acc_d     = fold_acc;
          run_ovf_d = run_ovf_q | fold_ovf;
          idx_d     = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (start && !finish_q) begin
          result_d = acc_q;
          ovf_d    = run_ovf_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q    <= '0;
      mode_q    <= MODE_USUM;
      acc_q     <= '0;
      run_ovf_q <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      opnd_q    <= opnd_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      run_ovf_q <= run_ovf_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign finish = finish_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
